// File: rtl/input_conditioner_if.sv
// input_conditioner_if: the raw board inputs, the card-availability mask and
// the conditioned outputs of the input conditioner, grouped as one bundle.
// master: the board side, which drives the raw levels and card_avail.
// slave: the conditioner, which drives the pulses and the selection.
// Signalling: level and pulse signals only, with no handshake. Each pulse_* is
// high for one clk cycle per accepted press. sel_* are registered levels.
interface input_conditioner_if;
    logic       btnCenter;
    logic       btnTop;
    logic       btnBottom;
    logic       btnLeft;
    logic       btnRight;
    logic [8:0] sw;
    logic [8:0] card_avail;
    logic       pulse_center;
    logic       pulse_top;
    logic       pulse_bottom;
    logic       pulse_left;
    logic       pulse_right;
    logic       sel_valid;
    logic [8:0] sel_onehot;
    logic [3:0] sel_index;

    modport master (
        output btnCenter, btnTop, btnBottom, btnLeft, btnRight, sw, card_avail,
        input  pulse_center, pulse_top, pulse_bottom, pulse_left, pulse_right,
        input  sel_valid, sel_onehot, sel_index
    );

    modport slave (
        input  btnCenter, btnTop, btnBottom, btnLeft, btnRight, sw, card_avail,
        output pulse_center, pulse_top, pulse_bottom, pulse_left, pulse_right,
        output sel_valid, sel_onehot, sel_index
    );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces the five board buttons into
// single prioritised press pulses, and turns the card-select switch bank into
// a validated one-hot / 1..9 index selection.
// Optional feature macro: SW_DEBOUNCE_EN. When it is defined, the switch vector
// is debounced with one shared counter. When it is undefined, the synchronised
// switches feed the selection logic directly.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input logic                 clk,
    input logic                 reset_n,
    input_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button bit order is also the pulse priority, with bit 0 the highest:
    // bottom, center, top, left, right.
    logic [4:0]       btn_raw;
    logic [4:0]       btn_sync1;
    logic [4:0]       btn_sync2;
    logic [4:0]       btn_stable;
    logic [4:0]       btn_stable_q;
    logic [4:0]       btn_rise;
    logic [4:0]       pulse_q;
    logic [CNT_W-1:0] btn_cnt [5];

    assign btn_raw = {bus.btnRight, bus.btnLeft, bus.btnTop, bus.btnCenter, bus.btnBottom};

    // Only a 0->1 change of the debounced level counts as a press.
    assign btn_rise = btn_stable & ~btn_stable_q;

    // Button synchronisers, per-button debounce and the one-hot priority pulse.
    // stable resets to 1, so a button held through reset must first be released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_sync1    <= '0;
            btn_sync2    <= '0;
            btn_stable   <= '1;
            btn_stable_q <= '1;
            pulse_q      <= '0;
            for (int i = 0; i < 5; i++) begin
                btn_cnt[i] <= '0;
            end
        end else begin
            btn_sync1    <= btn_raw;
            btn_sync2    <= btn_sync1;
            btn_stable_q <= btn_stable;
            // The lowest set bit wins. Presses that lose are dropped, not queued.
            pulse_q      <= btn_rise & (~btn_rise + 5'd1);
            for (int i = 0; i < 5; i++) begin
                if (btn_sync2[i] == btn_stable[i]) begin
                    btn_cnt[i] <= '0;
                end else if (btn_cnt[i] == CNT_MAX) begin
                    btn_stable[i] <= btn_sync2[i];
                    btn_cnt[i]    <= '0;
                end else begin
                    btn_cnt[i] <= btn_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.pulse_bottom = pulse_q[0];
    assign bus.pulse_center = pulse_q[1];
    assign bus.pulse_top    = pulse_q[2];
    assign bus.pulse_left   = pulse_q[3];
    assign bus.pulse_right  = pulse_q[4];

    logic [8:0] sw_sync1;
    logic [8:0] sw_sync2;
    logic [8:0] sw_stable;

    // Switch-bank two-flop synchroniser.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_sync1 <= '0;
            sw_sync2 <= '0;
        end else begin
            sw_sync1 <= bus.sw;
            sw_sync2 <= sw_sync1;
        end
    end

`ifdef SW_DEBOUNCE_EN
    logic [CNT_W-1:0] sw_cnt;

    // Shared switch debounce. A difference between the two synchroniser stages
    // means the synced vector changes on this edge, so the count restarts.
    // Once the count saturates, the synced value is loaded every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_cnt    <= '0;
            sw_stable <= '0;
        end else if (sw_sync1 != sw_sync2) begin
            sw_cnt <= '0;
        end else if (sw_cnt == CNT_MAX) begin
            sw_stable <= sw_sync2;
        end else begin
            sw_cnt <= sw_cnt + 1'b1;
        end
    end
`else
    assign sw_stable = sw_sync2;
`endif

    logic       sw_single;
    logic       sel_valid_d;
    logic [3:0] sel_index_d;

    // Selection decode. card_avail is synchronous to clk and is used directly.
    always_comb begin
        sw_single   = (sw_stable != 9'd0) && ((sw_stable & (sw_stable - 9'd1)) == 9'd0);
        sel_valid_d = sw_single && ((sw_stable & bus.card_avail) != 9'd0);
        sel_index_d = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (sw_stable[i]) begin
                sel_index_d = 4'(i + 1);
            end
        end
    end

    logic       sel_valid_q;
    logic [8:0] sel_onehot_q;
    logic [3:0] sel_index_q;

    // Registered selection outputs. They are forced to zero when the selection is invalid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_valid_q  <= 1'b0;
            sel_onehot_q <= '0;
            sel_index_q  <= '0;
        end else begin
            sel_valid_q  <= sel_valid_d;
            sel_onehot_q <= sel_valid_d ? sw_stable : 9'd0;
            sel_index_q  <= sel_valid_d ? sel_index_d : 4'd0;
        end
    end

    assign bus.sel_valid  = sel_valid_q;
    assign bus.sel_onehot = sel_onehot_q;
    assign bus.sel_index  = sel_index_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed vectors with hand-computed expectations for
// input_conditioner, using DEBOUNCE_CYCLES=4 and CNT_W=3.
module tb_input_conditioner;

    localparam int DC = 4;
`ifdef SW_DEBOUNCE_EN
    localparam int SW_EXTRA = DC;
`else
    localparam int SW_EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pc [5];
    logic [4:0] pv;

    input_conditioner_if ifc ();

    input_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    // Clock.
    always #5 clk = ~clk;

    // Bit order: bottom, center, top, left, right (bit 0 first).
    assign pv = {ifc.pulse_right, ifc.pulse_left, ifc.pulse_top, ifc.pulse_center, ifc.pulse_bottom};

    // Count pulse cycles per button. Sampling on the falling edge keeps clear of the active edge.
    initial for (int i = 0; i < 5; i++) pc[i] = 0;
    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) pc[i] = pc[i] + int'(pv[i]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and leave the bench 1 ns after the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int base [5];
        ifc.btnCenter = 0; ifc.btnTop = 0; ifc.btnBottom = 0;
        ifc.btnLeft = 0; ifc.btnRight = 0;
        ifc.sw = '0; ifc.card_avail = 9'h1FF;

        // Reset values, with reset still asserted.
        tick(3);
        check("rst_pulses", 32'(pv), 32'h0);
        check("rst_sel_valid", 32'(ifc.sel_valid), 32'h0);
        check("rst_sel_onehot", 32'(ifc.sel_onehot), 32'h0);
        check("rst_sel_index", 32'(ifc.sel_index), 32'h0);
        reset_n = 1'b1;
        // The debounced levels settle from 1 to 0, which must produce no pulse.
        tick(12);
        check("settle_no_pulse", 32'(pc[0] + pc[1] + pc[2] + pc[3] + pc[4]), 32'h0);

        // btnTop held. The pulse appears after the 7th edge counted from the first sample.
        ifc.btnTop = 1;
        tick(6);
        check("top_early", 32'(pv), 32'h0);
        tick(1);
        check("top_pulse", 32'(pv), 32'h4);
        tick(1);
        check("top_one_cycle", 32'(pv), 32'h0);
        tick(20);
        check("top_held_count", 32'(pc[2]), 32'd1);
        ifc.btnTop = 0;
        tick(12);
        check("top_release_count", 32'(pc[2]), 32'd1);

        // btnLeft glitches: 3 cycles high, 3 cycles low, never accepted.
        for (int r = 0; r < 6; r++) begin
            ifc.btnLeft = 1; tick(3);
            ifc.btnLeft = 0; tick(3);
        end
        tick(10);
        check("left_glitch_count", 32'(pc[3]), 32'd0);

        // Simultaneous presses: Bottom wins and Center is dropped.
        for (int i = 0; i < 5; i++) base[i] = pc[i];
        ifc.btnCenter = 1; ifc.btnBottom = 1;
        tick(15);
        check("simul_bottom", 32'(pc[0] - base[0]), 32'd1);
        check("simul_center_dropped", 32'(pc[1] - base[1]), 32'd0);
        ifc.btnCenter = 0; ifc.btnBottom = 0;
        tick(12);
        ifc.btnCenter = 1;
        tick(15);
        check("center_alone", 32'(pc[1] - base[1]), 32'd1);
        check("bottom_unchanged", 32'(pc[0] - base[0]), 32'd1);
        ifc.btnCenter = 0;
        tick(12);

        // btnRight held through reset gives no pulse until it is released and pressed again.
        base[4] = pc[4];
        ifc.btnRight = 1;
        tick(12);
        check("right_first_press", 32'(pc[4] - base[4]), 32'd1);
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        base[4] = pc[4];
        tick(15);
        check("right_held_reset", 32'(pc[4] - base[4]), 32'd0);
        ifc.btnRight = 0;
        tick(12);
        ifc.btnRight = 1;
        tick(15);
        check("right_repress", 32'(pc[4] - base[4]), 32'd1);
        ifc.btnRight = 0;
        tick(12);

        // Single switch on and available.
        ifc.card_avail = 9'h1FF;
        ifc.sw = 9'b000010000;
        tick(2 + SW_EXTRA);
        check("sw5_not_yet", 32'(ifc.sel_valid), 32'h0);
        tick(1);
        check("sw5_valid", 32'(ifc.sel_valid), 32'h1);
        check("sw5_index", 32'(ifc.sel_index), 32'd5);
        check("sw5_onehot", 32'(ifc.sel_onehot), 32'h010);
        // Card 5 is withdrawn, and the selection drops after one edge.
        ifc.card_avail = 9'h1EF;
        tick(1);
        check("avail_valid", 32'(ifc.sel_valid), 32'h0);
        check("avail_index", 32'(ifc.sel_index), 32'd0);
        check("avail_onehot", 32'(ifc.sel_onehot), 32'h0);

        // Two switches on: never valid.
        ifc.card_avail = 9'h1FF;
        ifc.sw = 9'b000000011;
        tick(3 + SW_EXTRA);
        check("two_sw_valid", 32'(ifc.sel_valid), 32'h0);
        check("two_sw_onehot", 32'(ifc.sel_onehot), 32'h0);
        check("two_sw_index", 32'(ifc.sel_index), 32'd0);
        // Switch 9: the index is 9 after 3 edges.
        ifc.sw = 9'b100000000;
        tick(2 + SW_EXTRA);
        check("sw9_not_yet", 32'(ifc.sel_index), 32'd0);
        tick(1);
        check("sw9_index", 32'(ifc.sel_index), 32'd9);
        check("sw9_valid", 32'(ifc.sel_valid), 32'h1);
        check("sw9_onehot", 32'(ifc.sel_onehot), 32'h100);

        // Asynchronous reset clears the selection without a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(ifc.sel_valid), 32'h0);
        check("async_rst_index", 32'(ifc.sel_index), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
